multi_freq_mixer: RTL and testbench
===================================

Name: multi_freq_mixer

Overview:
- Complex frequency-shift mixer in the DUC datapath: multiplies an incoming IQ sample stream by externally supplied NCO cos/sin coefficients.
- Computes (I + jQ)·(cos + j·sin) with a fixed pipeline latency.
- Carries the sample-valid and carrier-indicator (ca) sideband alongside the data.
- Sits between upstream IQ sample generation/interpolation and downstream DUC stages; the coefficient source (NCO) is external.

Parameters:
- DATA_W, 16, width of signed I/Q input and output samples (Q1.15).
- COEF_W, 16, width of signed sin/cos coefficients (Q1.15).
- LATENCY, 4, fixed input-to-output delay in clock cycles. Informational only, not user-changeable.

Ports:
- i_clk, in, 1, datapath clock (single clock domain).
- i_reset, in, 1, asynchronous active-low reset; 0 = reset asserted.
- i_data_vld, in, 1, input sample valid.
- i_data_ca, in, 1, carrier/antenna indicator, qualified by i_data_vld.
- i_data_i, in, DATA_W, signed input I sample.
- i_data_q, in, DATA_W, signed input Q sample.
- i_sin_coff, in, COEF_W, signed sin coefficient, sampled with the same-cycle data.
- i_cos_coff, in, COEF_W, signed cos coefficient, sampled with the same-cycle data.
- o_data_vld, out, 1, output sample valid.
- o_data_ca, out, 1, delayed carrier indicator.
- o_data_i, out, DATA_W, signed mixed I output.
- o_data_q, out, DATA_W, signed mixed Q output.

Behaviour:
- Arithmetic: out_i = I·cos − Q·sin; out_q = I·sin + Q·cos. All operands are two's-complement signed.
- Products are full 32-bit; sums are 33-bit, with no intermediate truncation.
- Scaling: Q2.30 sum → Q1.15 output.
  - Add 2^14, then arithmetic shift right by 15 (round half toward +inf).
  - Then saturate to [−32768, +32767].
- Pipeline, 4 cycles:
  - S1: register all inputs.
  - S2: four products.
  - S3: two sums.
  - S4: round, saturate, register outputs.
  - A sample presented at edge n appears on the outputs after edge n+4.
- No back-pressure; a new sample may be accepted every cycle. Coefficients are sampled per sample, so they may change every cycle.
- Sideband: vld and ca pass through a 4-deep shift register aligned with the data.
  - o_data_ca = delayed ca AND delayed vld.
- Output gating: when o_data_vld = 0, o_data_i = o_data_q = 0. Bubbles in i_data_vld appear as bubbles at the same positions.
- Reset (i_reset = 0, asynchronous assert):
  - All pipeline registers clear to 0; o_data_vld = 0, o_data_ca = 0, o_data_i = 0, o_data_q = 0.
  - In-flight samples are discarded.
  - Deassertion is synchronous to i_clk, handled by the upstream reset synchronizer.
  - First valid output appears 4 cycles after the first valid input following reset release.
- Boundary: (−32768)·(−32768) = 2^30 → 32768 → saturates to +32767. Every corner combination must saturate, never wrap.

Decomposition:
- Shared package (duc_pkg): DATA_W, COEF_W, MIX_LATENCY constants; signed sample typedef.
- One sub-module, mix_round_sat: 33-bit signed in, 16-bit round-and-saturate out. Instantiated twice (I and Q paths).
- Multipliers and adders stay in the top level.

Test Plan:
- cos = 32767, sin = 0, I = 1000, Q = −2000, vld = 1 → 4 cycles later o_data_i = 1000, o_data_q = −2000, o_data_vld = 1.
- cos = 0, sin = 32767, I = 1000, Q = −2000 → o_data_i = 2000, o_data_q = 1000 (90° rotation).
- Saturation:
  - I = −32768, Q = 0, cos = −32768, sin = 0 → o_data_i = 32767, o_data_q = 0.
  - I = Q = −32768, cos = −32768, sin = 32767 → o_data_i = 32767, o_data_q = 1.
- Valid/ca pattern: vld = 1,0,1,1 with ca = 1,1,0,1 → identical pattern 4 cycles later; o_data_ca = 1,0,0,1; o_data_i/q = 0 during the bubble.
- Reset mid-stream: assert i_reset = 0 for 2 cycles while 3 samples are in flight → all outputs 0 immediately (asynchronous), none of the in-flight samples emerge after release, and a new sample emerges exactly 4 cycles after it is applied.

Source files
------------

// File: rtl/duc_pkg.sv
// ---------------------------------------------------------------------------
// duc_pkg
// Shared constants and types for the DUC complex mixer datapath.
//   DATA_W      : width of signed I/Q samples (Q1.15)
//   COEF_W      : width of signed NCO sin/cos coefficients (Q1.15)
//   MIX_LATENCY : fixed input-to-output delay of multi_freq_mixer, in cycles
// Helpers:
//   mul_full  : full-precision signed sample x coefficient product
//   sext_prod : sign-extends a product by one bit so sums cannot wrap
// ---------------------------------------------------------------------------
package duc_pkg;

    localparam int DATA_W      = 16;
    localparam int COEF_W      = 16;
    localparam int MIX_LATENCY = 4;
    localparam int PROD_W      = DATA_W + COEF_W;
    localparam int SUM_W       = PROD_W + 1;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    // Both operands are widened to the product width before multiplying, so
    // the result is exact: |product| never exceeds 2^30.
    function automatic prod_t mul_full(input sample_t a, input coef_t b);
        return prod_t'(a) * prod_t'(b);
    endfunction

    // One guard bit: the sum of two full-scale products can reach 2^31.
    function automatic sum_t sext_prod(input prod_t p);
        return {p[PROD_W-1], p};
    endfunction

endpackage

// File: rtl/multi_freq_mixer_if.sv
// ---------------------------------------------------------------------------
// multi_freq_mixer_if
// Sample/coefficient stream into the mixer and mixed stream out of it.
//   i_data_vld  : input sample valid
//   i_data_ca   : carrier/antenna indicator, qualified by i_data_vld
//   i_data_i/q  : signed input I/Q sample
//   i_sin_coff  : signed NCO sin coefficient for the same-cycle sample
//   i_cos_coff  : signed NCO cos coefficient for the same-cycle sample
//   o_data_vld  : output sample valid
//   o_data_ca   : delayed carrier indicator (forced 0 when not valid)
//   o_data_i/q  : signed mixed I/Q output (forced 0 when not valid)
// Modports:
//   master : upstream side, drives the i_* signals and observes o_*
//   slave  : the mixer, consumes i_* and drives o_*
// ---------------------------------------------------------------------------
interface multi_freq_mixer_if;
    import duc_pkg::*;

    logic    i_data_vld;
    logic    i_data_ca;
    sample_t i_data_i;
    sample_t i_data_q;
    coef_t   i_sin_coff;
    coef_t   i_cos_coff;

    logic    o_data_vld;
    logic    o_data_ca;
    sample_t o_data_i;
    sample_t o_data_q;

    modport master (
        output i_data_vld, i_data_ca, i_data_i, i_data_q, i_sin_coff, i_cos_coff,
        input  o_data_vld, o_data_ca, o_data_i, o_data_q
    );

    modport slave (
        input  i_data_vld, i_data_ca, i_data_i, i_data_q, i_sin_coff, i_cos_coff,
        output o_data_vld, o_data_ca, o_data_i, o_data_q
    );

endinterface

// File: rtl/mix_round_sat.sv
// ---------------------------------------------------------------------------
// mix_round_sat
// Combinational Q2.30 -> Q1.15 conversion: round half toward +inf, then
// saturate to the signed DATA_W range so corner products never wrap.
//   sum_in  : SUM_W-bit signed sum of two Q1.15 x Q1.15 products
//   sat_out : DATA_W-bit signed rounded and saturated result
// ---------------------------------------------------------------------------
module mix_round_sat
    import duc_pkg::*;
(
    input  sum_t    sum_in,
    output sample_t sat_out
);

    // Coefficients are Q1.15, so the product carries DATA_W-1 extra fraction
    // bits; the bias is half an output LSB at that scale.
    localparam int   FRAC_SHIFT = DATA_W - 1;
    localparam sum_t ROUND_BIAS = sum_t'(1 << (FRAC_SHIFT - 1));
    localparam sum_t SAT_MAX    = sum_t'((1 << (DATA_W - 1)) - 1);
    localparam sum_t SAT_MIN    = sum_t'(-(1 << (DATA_W - 1)));

    sum_t biased;
    sum_t shifted;

    // The guard bit in sum_t keeps sum + bias from overflowing, and the
    // arithmetic shift floors, which with the bias gives round-half-up.
    always_comb begin
        biased  = sum_in + ROUND_BIAS;
        shifted = biased >>> FRAC_SHIFT;
        if (shifted > SAT_MAX) begin
            sat_out = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_out = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_out = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/multi_freq_mixer.sv
// ---------------------------------------------------------------------------
// multi_freq_mixer
// Complex frequency-shift mixer for the DUC: (I + jQ) * (cos + j*sin) with a
// fixed 4-cycle pipeline (register inputs, multiply, add, round/saturate).
// No back-pressure; one sample per cycle, coefficients sampled per sample.
//   i_clk   : datapath clock
//   i_reset : asynchronous active-low reset, clears every pipeline register
//   bus     : multi_freq_mixer_if.slave sample/coefficient stream in, mixed
//             stream out (see the interface header for signal meanings)
// ---------------------------------------------------------------------------
module multi_freq_mixer
    import duc_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    multi_freq_mixer_if.slave     bus
);

    // Stage 1: registered inputs
    logic    s1_vld_q,   s1_vld_d;
    logic    s1_ca_q,    s1_ca_d;
    sample_t s1_smp_i_q, s1_smp_i_d;
    sample_t s1_smp_q_q, s1_smp_q_d;
    coef_t   s1_cos_q,   s1_cos_d;
    coef_t   s1_sin_q,   s1_sin_d;

    // Stage 2: the four partial products
    logic    s2_vld_q, s2_vld_d;
    logic    s2_ca_q,  s2_ca_d;
    prod_t   s2_ic_q,  s2_ic_d;
    prod_t   s2_qs_q,  s2_qs_d;
    prod_t   s2_is_q,  s2_is_d;
    prod_t   s2_qc_q,  s2_qc_d;

    // Stage 3: full-precision sums
    logic    s3_vld_q,   s3_vld_d;
    logic    s3_ca_q,    s3_ca_d;
    sum_t    s3_sum_i_q, s3_sum_i_d;
    sum_t    s3_sum_q_q, s3_sum_q_d;

    // Stage 4: output registers
    logic    s4_vld_q,   s4_vld_d;
    logic    s4_ca_q,    s4_ca_d;
    sample_t s4_out_i_q, s4_out_i_d;
    sample_t s4_out_q_q, s4_out_q_d;

    sample_t rnd_i;
    sample_t rnd_q;

    mix_round_sat u_round_i (
        .sum_in  (s3_sum_i_q),
        .sat_out (rnd_i)
    );

    mix_round_sat u_round_q (
        .sum_in  (s3_sum_q_q),
        .sat_out (rnd_q)
    );

    // vld/ca ride alongside the data, forming the 4-deep sideband delay line.
    // Outputs are gated on the delayed valid so bubbles leave as zeros and a
    // stale ca never leaks out with an invalid slot.
    always_comb begin
        s1_vld_d   = bus.i_data_vld;
        s1_ca_d    = bus.i_data_ca;
        s1_smp_i_d = bus.i_data_i;
        s1_smp_q_d = bus.i_data_q;
        s1_cos_d   = bus.i_cos_coff;
        s1_sin_d   = bus.i_sin_coff;

        s2_vld_d   = s1_vld_q;
        s2_ca_d    = s1_ca_q;
        s2_ic_d    = mul_full(s1_smp_i_q, s1_cos_q);
        s2_qs_d    = mul_full(s1_smp_q_q, s1_sin_q);
        s2_is_d    = mul_full(s1_smp_i_q, s1_sin_q);
        s2_qc_d    = mul_full(s1_smp_q_q, s1_cos_q);

        s3_vld_d   = s2_vld_q;
        s3_ca_d    = s2_ca_q;
        s3_sum_i_d = sext_prod(s2_ic_q) - sext_prod(s2_qs_q);
        s3_sum_q_d = sext_prod(s2_is_q) + sext_prod(s2_qc_q);

        s4_vld_d   = s3_vld_q;
        s4_ca_d    = s3_ca_q & s3_vld_q;
        s4_out_i_d = s3_vld_q ? rnd_i : '0;
        s4_out_q_d = s3_vld_q ? rnd_q : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_vld_q   <= 1'b0;
            s1_ca_q    <= 1'b0;
            s1_smp_i_q <= '0;
            s1_smp_q_q <= '0;
            s1_cos_q   <= '0;
            s1_sin_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_ca_q    <= 1'b0;
            s2_ic_q    <= '0;
            s2_qs_q    <= '0;
            s2_is_q    <= '0;
            s2_qc_q    <= '0;
            s3_vld_q   <= 1'b0;
            s3_ca_q    <= 1'b0;
            s3_sum_i_q <= '0;
            s3_sum_q_q <= '0;
            s4_vld_q   <= 1'b0;
            s4_ca_q    <= 1'b0;
            s4_out_i_q <= '0;
            s4_out_q_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_ca_q    <= s1_ca_d;
            s1_smp_i_q <= s1_smp_i_d;
            s1_smp_q_q <= s1_smp_q_d;
            s1_cos_q   <= s1_cos_d;
            s1_sin_q   <= s1_sin_d;
            s2_vld_q   <= s2_vld_d;
            s2_ca_q    <= s2_ca_d;
            s2_ic_q    <= s2_ic_d;
            s2_qs_q    <= s2_qs_d;
            s2_is_q    <= s2_is_d;
            s2_qc_q    <= s2_qc_d;
            s3_vld_q   <= s3_vld_d;
            s3_ca_q    <= s3_ca_d;
            s3_sum_i_q <= s3_sum_i_d;
            s3_sum_q_q <= s3_sum_q_d;
            s4_vld_q   <= s4_vld_d;
            s4_ca_q    <= s4_ca_d;
            s4_out_i_q <= s4_out_i_d;
            s4_out_q_q <= s4_out_q_d;
        end
    end

    assign bus.o_data_vld = s4_vld_q;
    assign bus.o_data_ca  = s4_ca_q;
    assign bus.o_data_i   = s4_out_i_q;
    assign bus.o_data_q   = s4_out_q_q;

endmodule

// File: tb/tb_multi_freq_mixer.sv
// ---------------------------------------------------------------------------
// tb_multi_freq_mixer
// Directed vectors with hand-computed results for multi_freq_mixer. The
// stimulus process queues each expected output together with the cycle it
// is due; an independent monitor pops and compares whenever o_data_vld is
// high, and checks that idle slots are all-zero and nothing is overdue.
// ---------------------------------------------------------------------------
module tb_multi_freq_mixer;
    import duc_pkg::*;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;

    always #5 i_clk = ~i_clk;

    multi_freq_mixer_if mix_if ();

    multi_freq_mixer dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (mix_if.slave)
    );

    typedef struct {
        int due;
        int exp_i;
        int exp_q;
        int exp_ca;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Count of rising edges seen so far; a sample driven while cyc == c is
    // due on the outputs once cyc reaches c + MIX_LATENCY.
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Monitor: runs 1 time unit after each falling clock edge and after any
    // reset assertion, so an asynchronous clear is observed immediately.
    always begin
        @(negedge i_clk or negedge i_reset);
        #1;
        if (mix_if.o_data_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out: actual=vld 1 i=%0d q=%0d required=vld 0 (cycle %0d)",
                         mix_if.o_data_i, mix_if.o_data_q, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("latency_cycle", cyc, mon_e.due);
                checkOutput("out_i", int'(mix_if.o_data_i), mon_e.exp_i);
                checkOutput("out_q", int'(mix_if.o_data_q), mon_e.exp_q);
                checkOutput("out_ca", int'(mix_if.o_data_ca), mon_e.exp_ca);
            end
        end else begin
            checkOutput("idle_vld", int'(mix_if.o_data_vld), 0);
            checkOutput("idle_i", int'(mix_if.o_data_i), 0);
            checkOutput("idle_q", int'(mix_if.o_data_q), 0);
            checkOutput("idle_ca", int'(mix_if.o_data_ca), 0);
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_out: actual=no valid output required=i %0d q %0d due cycle %0d (cycle %0d)",
                         sb_q[0].exp_i, sb_q[0].exp_q, sb_q[0].due, cyc);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input int vld, input int ca, input int di, input int dq,
                                 input int cos_c, input int sin_c, input int ei, input int eq);
        exp_t e;
        @(negedge i_clk);
        mix_if.i_data_vld = vld[0];
        mix_if.i_data_ca  = ca[0];
        mix_if.i_data_i   = sample_t'(di);
        mix_if.i_data_q   = sample_t'(dq);
        mix_if.i_cos_coff = coef_t'(cos_c);
        mix_if.i_sin_coff = coef_t'(sin_c);
        if (vld != 0) begin
            e.due    = cyc + MIX_LATENCY;
            e.exp_i  = ei;
            e.exp_q  = eq;
            e.exp_ca = ca;
            sb_q.push_back(e);
        end
    endtask

    task automatic applyIdle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        mix_if.i_data_vld = 1'b0;
        mix_if.i_data_ca  = 1'b0;
        mix_if.i_data_i   = '0;
        mix_if.i_data_q   = '0;
        mix_if.i_cos_coff = '0;
        mix_if.i_sin_coff = '0;

        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        $display("[TB] reset released");

        // Back-to-back samples with coefficients changing every cycle
        //            vld ca   I       Q       cos     sin     exp_i   exp_q
        applyStimulus(1,  1,   1000,  -2000,   32767,  0,      1000,  -2000);
        applyStimulus(1,  0,   1000,  -2000,   0,      32767,  2000,   1000);
        applyStimulus(1,  1,  -32768,  0,     -32768,  0,      32767,  0);
        applyStimulus(1,  0,  -32768, -32768, -32768,  32767,  32767,  1);
        applyStimulus(1,  1,  -32768, -32768, -32768, -32768,  0,      32767);
        applyStimulus(1,  0,  -32768,  32767,  32767,  32767, -32768, -1);
        applyStimulus(1,  1,   1,      0,      16384,  0,      1,      0);
        applyStimulus(1,  1,  -1,      0,      16384,  0,      0,      0);
        applyIdle(6);

        // Valid/ca pattern with a bubble carrying non-zero data and ca = 1
        $display("[TB] valid/ca bubble pattern");
        applyStimulus(1,  1,   100,    200,    32767,  0,      100,    200);
        applyStimulus(0,  1,   5000,   6000,   32767,  1000,   0,      0);
        applyStimulus(1,  0,   100,    200,    32767,  0,      100,    200);
        applyStimulus(1,  1,   100,    200,    32767,  0,      100,    200);
        applyIdle(6);

        // Reset mid-stream: first sample reaches the outputs, three remain
        // in flight and must be discarded.
        $display("[TB] reset with samples in flight");
        applyStimulus(1,  1,   1000,  -2000,   32767,  0,      1000,  -2000);
        applyStimulus(1,  1,   1000,  -2000,   32767,  0,      1000,  -2000);
        applyStimulus(1,  0,   1000,  -2000,   32767,  0,      1000,  -2000);
        applyStimulus(1,  1,   1000,  -2000,   32767,  0,      1000,  -2000);
        applyIdle(1);
        #2;
        i_reset = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        applyIdle(6);

        applyStimulus(1,  1,   1000,  -2000,   0,      32767,  2000,   1000);
        applyIdle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
